// File: rtl/sync_fifo_pkg.sv
// Shared helpers and types for the single-clock FIFO family.
package sync_fifo_pkg;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_sdp_ram
  import sync_fifo_pkg::*;
#(
  parameter int G_WIDTH = 8,
  parameter int G_DEPTH = 10,
  parameter int AW      = ptr_width(G_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [G_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [G_WIDTH-1:0] o_rdata
);

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];

  // Contents are deliberately not reset; the level register gates what is visible.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read,
// programmable almost thresholds, fill level and sticky error flags.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int G_WIDTH  = 8,
  parameter int G_DEPTH  = 10,
  parameter int G_FWFT   = 0,
  parameter int G_AFULL  = G_DEPTH - 2,
  parameter int G_AEMPTY = 2,
  localparam int LW      = level_width(G_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr,
  input  logic [G_WIDTH-1:0] i_data,
  input  logic               i_rd,
  input  logic               i_clr_err,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_rd_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_afull,
  output logic               o_aempty,
  output logic [LW-1:0]      o_level,
  output logic               o_overflow,
  output logic               o_underflow,
  output logic               o_ovf_sticky,
  output logic               o_udf_sticky
);

  localparam int PW = ptr_width(G_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(G_DEPTH - 1);

  if (G_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_fwft: G_WIDTH must be >= 1");
  end
  if (G_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_fwft: G_DEPTH must be >= 2");
  end
  if (G_AFULL < 1 || G_AFULL > G_DEPTH) begin : g_bad_afull
    $error("sync_fifo_fwft: G_AFULL must be in 1..G_DEPTH");
  end
  if (G_AEMPTY < 0 || G_AEMPTY > G_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_fwft: G_AEMPTY must be in 0..G_DEPTH-1");
  end

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_sticky_q, ovf_sticky_d;
  logic               udf_sticky_q, udf_sticky_d;
  logic [G_WIDTH-1:0] ram_rdata;
  logic               wa, ra;
  fifo_status_t       status;

  assign status = '{
    full:   (level_q == LW'(G_DEPTH)),
    empty:  (level_q == '0),
    afull:  (level_q >= LW'(G_AFULL)),
    aempty: (level_q <= LW'(G_AEMPTY))
  };

  // Accepts look only at registered state: no bypass on full, no read-through on empty.
  assign wa = i_wr && !status.full;
  assign ra = i_rd && !status.empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    ovf_sticky_d = ovf_sticky_q;
    udf_sticky_d = udf_sticky_q;
    if (wa) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (ra) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wa, ra})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (i_clr_err) begin
      ovf_sticky_d = 1'b0;
      udf_sticky_d = 1'b0;
    end
    if (o_overflow) begin
      ovf_sticky_d = 1'b1;
    end
    if (o_underflow) begin
      udf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  fifo_sdp_ram #(
    .G_WIDTH (G_WIDTH),
    .G_DEPTH (G_DEPTH),
    .AW      (PW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wa),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (ram_rdata)
  );

  if (G_FWFT != 0) begin : g_fwft
    // Head word is masked while empty so o_data reads 0 out of reset.
    assign o_data     = status.empty ? '0 : ram_rdata;
    assign o_rd_valid = !status.empty;
  end else begin : g_std
    logic [G_WIDTH-1:0] data_q, data_d;
    logic               rd_valid_q, rd_valid_d;

    always_comb begin
      data_d     = data_q;
      rd_valid_d = 1'b0;
      if (ra) begin
        data_d     = ram_rdata;
        rd_valid_d = 1'b1;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        data_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        data_q     <= data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign o_data     = data_q;
    assign o_rd_valid = rd_valid_q;
  end

  assign o_full       = status.full;
  assign o_empty      = status.empty;
  assign o_afull      = status.afull;
  assign o_aempty     = status.aempty;
  assign o_level      = level_q;
  assign o_overflow   = i_wr && status.full;
  assign o_underflow  = i_rd && status.empty;
  assign o_ovf_sticky = ovf_sticky_q;
  assign o_udf_sticky = udf_sticky_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives a standard-mode and an FWFT-mode FIFO with the same stimulus and checks both
// against a queue-based reference model.
module tb_sync_fifo_fwft;

  localparam int W  = 8;
  localparam int D  = 6;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int LW = 3;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_wr = 1'b0;
  logic          i_rd = 1'b0;
  logic          i_clr_err = 1'b0;
  logic [W-1:0]  i_data = '0;

  logic [W-1:0]  s_data, f_data;
  logic          s_rd_valid, f_rd_valid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_afull, f_afull, s_aempty, f_aempty;
  logic [LW-1:0] s_level, f_level;
  logic          s_overflow, f_overflow, s_underflow, f_underflow;
  logic          s_ovf_sticky, f_ovf_sticky, s_udf_sticky, f_udf_sticky;

  always #5 i_clk = ~i_clk;

  sync_fifo_fwft #(.G_WIDTH(W), .G_DEPTH(D), .G_FWFT(0), .G_AFULL(AF), .G_AEMPTY(AE)) dut_std (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
    .i_clr_err(i_clr_err), .o_data(s_data), .o_rd_valid(s_rd_valid), .o_full(s_full),
    .o_empty(s_empty), .o_afull(s_afull), .o_aempty(s_aempty), .o_level(s_level),
    .o_overflow(s_overflow), .o_underflow(s_underflow), .o_ovf_sticky(s_ovf_sticky),
    .o_udf_sticky(s_udf_sticky)
  );

  sync_fifo_fwft #(.G_WIDTH(W), .G_DEPTH(D), .G_FWFT(1), .G_AFULL(AF), .G_AEMPTY(AE)) dut_fwft (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
    .i_clr_err(i_clr_err), .o_data(f_data), .o_rd_valid(f_rd_valid), .o_full(f_full),
    .o_empty(f_empty), .o_afull(f_afull), .o_aempty(f_aempty), .o_level(f_level),
    .o_overflow(f_overflow), .o_underflow(f_underflow), .o_ovf_sticky(f_ovf_sticky),
    .o_udf_sticky(f_udf_sticky)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Reference model: contents as a queue plus the few observable registers.
  logic [W-1:0] model_q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  logic [W-1:0] m_std_data = '0;
  logic         m_std_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf       = 1'b0;
    m_udf       = 1'b0;
    m_std_data  = '0;
    m_std_valid = 1'b0;
  endtask

  task automatic check_state(input string where);
    int n;
    logic [W-1:0] head;
    n = model_q.size();
    head = (n > 0) ? model_q[0] : '0;
    check_eq({where, ":s_level"},  32'(s_level),  32'(n));
    check_eq({where, ":f_level"},  32'(f_level),  32'(n));
    check_eq({where, ":s_full"},   32'(s_full),   32'(n == D));
    check_eq({where, ":f_full"},   32'(f_full),   32'(n == D));
    check_eq({where, ":s_empty"},  32'(s_empty),  32'(n == 0));
    check_eq({where, ":f_empty"},  32'(f_empty),  32'(n == 0));
    check_eq({where, ":s_afull"},  32'(s_afull),  32'(n >= AF));
    check_eq({where, ":f_afull"},  32'(f_afull),  32'(n >= AF));
    check_eq({where, ":s_aempty"}, 32'(s_aempty), 32'(n <= AE));
    check_eq({where, ":f_aempty"}, 32'(f_aempty), 32'(n <= AE));
    check_eq({where, ":s_ovf_sticky"}, 32'(s_ovf_sticky), 32'(m_ovf));
    check_eq({where, ":f_ovf_sticky"}, 32'(f_ovf_sticky), 32'(m_ovf));
    check_eq({where, ":s_udf_sticky"}, 32'(s_udf_sticky), 32'(m_udf));
    check_eq({where, ":f_udf_sticky"}, 32'(f_udf_sticky), 32'(m_udf));
    check_eq({where, ":s_rd_valid"}, 32'(s_rd_valid), 32'(m_std_valid));
    check_eq({where, ":s_data"},     32'(s_data),     32'(m_std_data));
    check_eq({where, ":f_rd_valid"}, 32'(f_rd_valid), 32'(n > 0));
    check_eq({where, ":f_data"},     32'(f_data),     32'(head));
  endtask

  // One clock cycle of stimulus: drive on falling edge, check combinational error
  // outputs before the rising edge, update the model at the edge, then check state.
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] din, input logic clr);
    int  n;
    logic wa, ra;
    @(negedge i_clk);
    i_wr = wr;
    i_rd = rd;
    i_data = din;
    i_clr_err = clr;
    #1;
    n = model_q.size();
    check_eq("s_overflow",  32'(s_overflow),  32'(wr && n == D));
    check_eq("f_overflow",  32'(f_overflow),  32'(wr && n == D));
    check_eq("s_underflow", 32'(s_underflow), 32'(rd && n == 0));
    check_eq("f_underflow", 32'(f_underflow), 32'(rd && n == 0));
    wa = wr && (n < D);
    ra = rd && (n > 0);
    @(posedge i_clk);
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (wr && n == D) m_ovf = 1'b1;
    if (rd && n == 0) m_udf = 1'b1;
    m_std_valid = ra;
    if (ra) m_std_data = model_q.pop_front();
    if (wa) model_q.push_back(din);
    #1;
    cyc++;
    $display("[TB] cyc %0d wr=%0d rd=%0d clr=%0d din=%02h level=%0d s_data=%02h f_data=%02h",
             cyc, wr, rd, clr, din, model_q.size(), s_data, f_data);
    check_state("step");
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    // Power-up reset, checked before any clock edge.
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    check_state("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Fill 0x11..0x16 then drain in order.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0, 1'b0);
    idle();

    // Overflow on full, sticky, clear, and the rejected word never appears.
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'(8'h21 + i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    idle();
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0, 1'b0);

    // Read and write together on an empty FIFO: read rejected, write accepted.
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Steady level 3 across pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b0);

    // FWFT fall-through and acknowledge.
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    idle();
    step(1'b0, 1'b1, '0, 1'b0);
    idle();

    // Set both stickies, settle at level 4, then reset asynchronously mid-cycle.
    step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 8'(8'h41 + i), 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    @(negedge i_clk);
    i_wr = 1'b0;
    i_rd = 1'b0;
    i_clr_err = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    step(1'b1, 1'b0, 8'h77, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    idle();

    // Random traffic: write-heavy first half, read-heavy second half.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 65 : 35;
      step(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < (100 - wp)),
           8'($urandom), 1'($urandom_range(0, 99) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Single-clock, parametrised synchronous FIFO. It is the next generation of the team's dual-domain FIFO. It adds:
- arbitrary (non-power-of-two) depth;
- a selectable first-word-fall-through (FWFT) or standard read mode;
- programmable almost-full and almost-empty thresholds;
- a fill-level output;
- sticky error flags.

It is used as the generic buffering element between same-clock pipeline stages.

Parameters:
G_WIDTH, 8, data word width in bits (≥1).
G_DEPTH, 10, number of storage entries (≥2, any integer, not restricted to powers of two).
G_FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = FWFT (head word presented on o_data).
G_AFULL, G_DEPTH-2, o_afull asserted when level ≥ G_AFULL (1..G_DEPTH).
G_AEMPTY, 2, o_aempty asserted when level ≤ G_AEMPTY (0..G_DEPTH-1).

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_wr  in  1  write request.
i_data  in  G_WIDTH  write data.
i_rd  in  1  read request; in FWFT mode, acknowledge of the head word.
i_clr_err  in  1  synchronous clear of the sticky error flags.
o_data  out  G_WIDTH  read data.
o_rd_valid  out  1  standard mode: o_data updated this cycle; FWFT mode: o_data holds a valid head word.
o_full  out  1  level == G_DEPTH.
o_empty  out  1  level == 0.
o_afull  out  1  level ≥ G_AFULL.
o_aempty  out  1  level ≤ G_AEMPTY.
o_level  out  LW  current fill level, LW = $clog2(G_DEPTH+1).
o_overflow  out  1  combinational: i_wr && o_full.
o_underflow  out  1  combinational: i_rd && o_empty.
o_ovf_sticky  out  1  a write has been rejected since the last clear or reset.
o_udf_sticky  out  1  a read has been rejected since the last clear or reset.

Behaviour:
- Reset (async assert, release synchronised by the environment):
  - wr_ptr, rd_ptr, level = 0.
  - o_empty = 1, o_aempty = 1; o_full = 0; o_afull = 0 (since G_AFULL ≥ 1).
  - o_data = 0; o_rd_valid = 0; both sticky flags = 0.
  - Memory contents are not reset.
- Write accept: wa = i_wr && !o_full. No write-through-on-full bypass, even when a read is accepted in the same cycle.
- Read accept: ra = i_rd && !o_empty. A simultaneous write into an empty FIFO does not satisfy the read.
- Pointers:
  - Range 0..G_DEPTH-1; wrap explicitly to 0 after G_DEPTH-1 (compare, not modulo-2^n).
  - wr_ptr advances on wa; rd_ptr advances on ra.
- Level register:
  - +1 on wa && !ra; -1 on ra && !wa; unchanged on both or neither.
  - All status flags are derived combinationally from the level register, so they update the cycle after the causing accept.
- Standard mode (G_FWFT=0):
  - On ra, o_data <= mem[rd_ptr] and o_rd_valid pulses 1 the following cycle.
  - Otherwise o_data holds its value and o_rd_valid = 0.
- FWFT mode (G_FWFT=1):
  - o_data = mem[rd_ptr] and o_rd_valid = !o_empty.
  - A word written into an empty FIFO appears 1 cycle after its write edge.
  - On ra, the next word (or o_rd_valid = 0) appears the cycle after the acknowledge edge.
- Memory writes to the same address as the current read are not possible: wa requires not full, ra requires not empty.
- Sticky flags:
  - Set on the edge where o_overflow / o_underflow is 1.
  - Cleared on an edge with i_clr_err = 1.
  - Set has priority over clear in the same cycle.
- Rejected operations change no pointer, level or memory state.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); buffered data is discarded.
- Elaboration errors are required for illegal G_DEPTH, G_AFULL or G_AEMPTY values.

Decomposition:
- Package sync_fifo_pkg:
  - localparam-style function for the level width;
  - a typedef of the status bundle (full, empty, afull, aempty) for reuse by higher-level wrappers.
- One sub-module, fifo_sdp_ram: G_WIDTH × G_DEPTH, one write port, one asynchronous read port.
- Pointer, level and flag logic stay in sync_fifo_fwft.

Test Plan:
All scenarios use G_WIDTH=8, G_DEPTH=6, G_AFULL=4, G_AEMPTY=1.
1. Reset, then write 0x11..0x16 on consecutive cycles (standard mode):
   - o_level steps 1..6;
   - o_aempty drops when level reaches 2; o_afull rises when level reaches 4;
   - o_full = 1 after the 6th write.
   Then read 6 times: o_data = 0x11..0x16, each with o_rd_valid 1 cycle after its read; o_empty = 1 at the end.
2. FIFO full, i_wr=1 with 0xAA:
   - o_overflow = 1 that cycle; o_ovf_sticky = 1 next cycle;
   - level stays 6; 0xAA is never read back.
   Then i_clr_err=1 → sticky = 0 next cycle.
3. FIFO empty, i_rd=1 and i_wr=1 (0x5A) in the same cycle:
   - o_underflow = 1; o_udf_sticky set; level = 1 next cycle;
   - next read returns 0x5A.
4. Wrap-around: 20 interleaved write/read pairs at level 3 (simultaneous wr+rd each cycle):
   - level constant at 3;
   - data order preserved across pointer wrap at index 5→0.
5. FWFT mode, write 0x3C into empty FIFO:
   - o_data = 0x3C with o_rd_valid = 1 one cycle later, no i_rd needed;
   - ack with i_rd → o_rd_valid = 0 the next cycle.
6. Assert i_rst asynchronously mid-cycle at level 4 with the sticky flags set:
   - outputs go to reset values without waiting for a clock edge;
   - after release, the first write/read returns the newly written data.
